// File: rtl/sram_port_arbiter_if.sv
// Client request/acknowledge bus plus the external asynchronous SRAM pins
// that sram_port_arbiter drives.
interface sram_port_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 21,
    parameter int DW  = 8
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     dout;
    logic              busy;
    logic [AW-1:0]     SRAM_ADDR;
    logic [DW-1:0]     SRAM_DATA_i;
    logic [DW-1:0]     SRAM_DATA_o;
    logic              SRAM_WE_n;
    logic              SRAM_OE_n;

    modport slave (
        input  req, we, addr, din, SRAM_DATA_i,
        output ack, dout, busy, SRAM_ADDR, SRAM_DATA_o, SRAM_WE_n, SRAM_OE_n
    );

    modport master (
        output req, we, addr, din, SRAM_DATA_i,
        input  ack, dout, busy, SRAM_ADDR, SRAM_DATA_o, SRAM_WE_n, SRAM_OE_n
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// N-channel request/ack arbiter onto one asynchronous SRAM port with wait states
// and a write-recovery cycle. Define SRAM_ARB_ROUND_ROBIN_EN for round-robin grant.
module sram_port_arbiter #(
    parameter int NCH      = 4,
    parameter int AW       = 21,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic               clka,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [GW-1:0] grant_reg, grant_next;
    logic [3:0]    wait_reg, wait_next;
    logic [NCH-1:0] ack_reg, ack_next;
    logic          busy_reg, busy_next;
    logic          we_n_reg, we_n_next;
    logic          oe_n_reg, oe_n_next;
    logic [AW-1:0] sram_addr_reg, sram_addr_next;
    logic [DW-1:0] sram_wdata_reg, sram_wdata_next;
    logic [DW-1:0] dout_reg, dout_next;

    logic [AW-1:0] addr_ch [NCH];
    logic [DW-1:0] din_ch  [NCH];
    logic          sel_valid;
    logic [GW-1:0] sel_idx;
    logic [GW-1:0] scan_idx;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign addr_ch[gi] = bus.addr[gi*AW +: AW];
            assign din_ch[gi]  = bus.din[gi*DW +: DW];
        end
    endgenerate

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_reg, ptr_next;
    int            rr_pos;

    // Scan downward so the channel closest to the pointer is the last one written.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        rr_pos    = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            rr_pos = int'(ptr_reg) + k;
            if (rr_pos >= NCH) begin
                rr_pos = rr_pos - NCH;
            end
            scan_idx = GW'(rr_pos);
            if (bus.req[scan_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end
`else
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            scan_idx = GW'(k);
            if (bus.req[scan_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end
`endif

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        wait_next       = wait_reg;
        ack_next        = '0;
        busy_next       = busy_reg;
        we_n_next       = we_n_reg;
        oe_n_next       = oe_n_reg;
        sram_addr_next  = sram_addr_reg;
        sram_wdata_next = sram_wdata_reg;
        dout_next       = dout_reg;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ptr_next        = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    grant_next      = sel_idx;
                    sram_addr_next  = addr_ch[sel_idx];
                    sram_wdata_next = din_ch[sel_idx];
                    we_n_next       = ~bus.we[sel_idx];
                    oe_n_next       = bus.we[sel_idx];
                    wait_next       = 4'(WAIT_CYC);
                    busy_next       = 1'b1;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_reg != 4'd0) begin
                    wait_next = wait_reg - 4'd1;
                end else begin
                    // A low OE_n marks this access as a read.
                    if (!oe_n_reg) begin
                        dout_next = bus.SRAM_DATA_i;
                    end
                    ack_next[grant_reg] = 1'b1;
                    we_n_next           = 1'b1;
                    oe_n_next           = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    ptr_next = (grant_reg == GW'(NCH - 1)) ? '0 : grant_reg + GW'(1);
`endif
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                // Address and write data stay put here to give the SRAM hold time.
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            wait_reg       <= '0;
            ack_reg        <= '0;
            busy_reg       <= 1'b0;
            we_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            dout_reg       <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            wait_reg       <= wait_next;
            ack_reg        <= ack_next;
            busy_reg       <= busy_next;
            we_n_reg       <= we_n_next;
            oe_n_reg       <= oe_n_next;
            sram_addr_reg  <= sram_addr_next;
            sram_wdata_reg <= sram_wdata_next;
            dout_reg       <= dout_next;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_reg        <= ptr_next;
`endif
        end
    end

    assign bus.ack         = ack_reg;
    assign bus.busy        = busy_reg;
    assign bus.dout        = dout_reg;
    assign bus.SRAM_ADDR   = sram_addr_reg;
    assign bus.SRAM_DATA_o = sram_wdata_reg;
    assign bus.SRAM_WE_n   = we_n_reg;
    assign bus.SRAM_OE_n   = oe_n_reg;
endmodule
